// File: rtl/ttt_move_arbiter.sv
// ttt_move_arbiter: shares the ttt_ctrl key-pulse inputs between the UART
// player (source 0) and the board buttons / second player (source 1).
// Enforces turn ownership and serialises accepted keys into single-cycle
// pulses. It also holds off after enter/space so ttt_ctrl can settle, and
// runs a per-turn inactivity timeout.
// Optional build macro TTT_AUTO_MOVE_EN: a timeout also fires an enter pulse
// on behalf of the current player, placing a mark at the cursor.
module ttt_move_arbiter #(
   parameter int TIMEOUT_CYCLES = 250000000,
   parameter int ENTER_WAIT     = 16,
   parameter int HOLDOFF        = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       src0_valid,
   input  logic [2:0] src0_key,
   output logic       src0_ready,
   input  logic       src1_valid,
   input  logic [2:0] src1_key,
   output logic       src1_ready,
   input  logic       current_player,
   input  logic [1:0] win_flag,
   output logic       up,
   output logic       down,
   output logic       left,
   output logic       right,
   output logic       enter,
   output logic       space,
   output logic       grant_src,
   output logic       drop,
   output logic       turn_timeout
);

   localparam int TW   = $clog2(TIMEOUT_CYCLES);
   localparam int WMAX = (ENTER_WAIT > HOLDOFF) ? ENTER_WAIT : HOLDOFF;
   localparam int WW   = $clog2(WMAX + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [WW-1:0] EW_LAST = WW'(ENTER_WAIT - 1);
   localparam logic [WW-1:0] HO_LAST = WW'(HOLDOFF - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_TURN,
      S_HOLDOFF
   } state_t;

   state_t        state_q, state_d;
   logic [WW-1:0] wcnt_q, wcnt_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          cp_q;
   logic [5:0]    key_q, key_d;
   logic          drop_q;
   logic          grant_q, grant_d;

   logic       idle, game_over, toggle, any_valid, sel, xfer, elig;
   logic       at_limit, fire, auto_fire;
   logic [2:0] sel_key;

   assign idle      = (state_q == S_IDLE) && !reset;
   assign game_over = |win_flag;
   assign toggle    = current_player ^ cp_q;
   assign any_valid = src0_valid | src1_valid;
   // On contention the turn owner wins; otherwise whoever is valid.
   assign sel       = (src0_valid && src1_valid) ? current_player : src1_valid;
   assign sel_key   = sel ? src1_key : src0_key;
   assign xfer      = idle && any_valid;
   // Space is always honoured (new game); moves only from the owner mid-game.
   assign elig      = xfer && ((sel_key == 3'd5) ||
                      ((sel_key <= 3'd4) && (sel == current_player) && !game_over));
   assign at_limit  = (tcnt_q == TO_LAST);
   // Any pending key beats the timeout, since it is accepted this cycle.
   assign fire      = idle && !game_over && !toggle && !any_valid && at_limit;

`ifdef TTT_AUTO_MOVE_EN
   assign auto_fire = fire;
`else
   assign auto_fire = 1'b0;
`endif

   assign src0_ready   = xfer && !sel;
   assign src1_ready   = xfer && sel;
   assign turn_timeout = fire;
   assign up           = key_q[0];
   assign down         = key_q[1];
   assign left         = key_q[2];
   assign right        = key_q[3];
   assign enter        = key_q[4] | auto_fire;
   assign space        = key_q[5];
   assign drop         = drop_q;
   assign grant_src    = auto_fire ? current_player : grant_q;

   // Next state: settle windows after enter/space, navigation stays in IDLE.
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         S_IDLE: begin
            wcnt_d = '0;
            if (elig && sel_key == 3'd4)      state_d = S_WAIT_TURN;
            else if (elig && sel_key == 3'd5) state_d = S_HOLDOFF;
            else if (auto_fire)               state_d = S_WAIT_TURN;
         end
         S_WAIT_TURN: begin
            if (toggle || game_over || wcnt_q == EW_LAST) begin
               state_d = S_IDLE;
               wcnt_d  = '0;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         S_HOLDOFF: begin
            if (wcnt_q == HO_LAST) begin
               state_d = S_IDLE;
               wcnt_d  = '0;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            wcnt_d  = '0;
         end
      endcase
   end

   // Inactivity count, key pulse decode and grant tracking.
   always_comb begin
      tcnt_d = tcnt_q;
      if (!idle || game_over || toggle || elig || fire) tcnt_d = '0;
      else if (!at_limit)                               tcnt_d = tcnt_q + 1'b1;
      key_d   = elig ? (6'b000001 << sel_key) : 6'b000000;
      grant_d = grant_q;
      if (elig)           grant_d = sel;
      else if (auto_fire) grant_d = current_player;
   end

   // State and output registers; reset drops whatever was in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         wcnt_q  <= '0;
         tcnt_q  <= '0;
         cp_q    <= current_player;
         key_q   <= '0;
         drop_q  <= 1'b0;
         grant_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         tcnt_q  <= tcnt_d;
         cp_q    <= current_player;
         key_q   <= key_d;
         drop_q  <= xfer && !elig;
         grant_q <= grant_d;
      end
   end

endmodule

// File: tb/tb_ttt_move_arbiter.sv
// Scoreboard bench for ttt_move_arbiter (TIMEOUT_CYCLES=20, ENTER_WAIT=4,
// HOLDOFF=3). Stimulus pushes the expected output events with their cycle
// numbers; the monitor pops one whenever any ready/pulse output is high.
module tb_ttt_move_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       src0_valid = 1'b0, src1_valid = 1'b0;
   logic [2:0] src0_key = 3'd0, src1_key = 3'd0;
   logic       src0_ready, src1_ready;
   logic       current_player = 1'b0;
   logic [1:0] win_flag = 2'b00;
   logic       up, down, left, right, enter, space, grant_src, drop, turn_timeout;

   ttt_move_arbiter #(.TIMEOUT_CYCLES(20), .ENTER_WAIT(4), .HOLDOFF(3)) dut (
      .clk(clk), .reset(reset),
      .src0_valid(src0_valid), .src0_key(src0_key), .src0_ready(src0_ready),
      .src1_valid(src1_valid), .src1_key(src1_key), .src1_ready(src1_ready),
      .current_player(current_player), .win_flag(win_flag),
      .up(up), .down(down), .left(left), .right(right), .enter(enter), .space(space),
      .grant_src(grant_src), .drop(drop), .turn_timeout(turn_timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   localparam logic [5:0] K_NONE  = 6'b000000;
   localparam logic [5:0] K_UP    = 6'b000001;
   localparam logic [5:0] K_DOWN  = 6'b000010;
   localparam logic [5:0] K_LEFT  = 6'b000100;
   localparam logic [5:0] K_RIGHT = 6'b001000;
   localparam logic [5:0] K_ENTER = 6'b010000;
   localparam logic [5:0] K_SPACE = 6'b100000;

   // ev = {src0_ready, src1_ready, space..up, drop, turn_timeout}
   typedef struct {
      int         cyc;
      logic [9:0] ev;
      logic       g;
   } exp_t;
   exp_t sb[$];

   int   checks = 0;
   int   errors = 0;
   logic chk_zero = 1'b0;
   logic chk_end = 1'b0;
   logic end_done = 1'b0;

   function automatic void exp_ev(int c, logic r0, logic r1, logic [5:0] k,
                                  logic d, logic t, logic g);
      exp_t e;
      e.cyc = c;
      e.ev  = {r0, r1, k, d, t};
      e.g   = g;
      sb.push_back(e);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      src0_valid = 1'b0;
      src1_valid = 1'b0;
      tick();
      chk_zero = 1'b1;
      tick();
      chk_zero = 1'b0;
      reset = 1'b0;
   endtask

   // Monitor: all checking lives here.
   logic [9:0] mon_ev;
   exp_t       mon_e;
   always @(negedge clk) begin
      mon_ev = {src0_ready, src1_ready, space, enter, right, left, down, up, drop, turn_timeout};
      if (chk_zero) begin
         checks++;
         if (mon_ev != 10'd0 || grant_src != 1'b0) begin
            errors++;
            $display("FAIL reset_zero cyc=%0d got ev=%b grant=%b want all zero", cyc, mon_ev, grant_src);
         end
      end
      if (!reset && mon_ev != 10'd0) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d got ev=%b grant=%b want none", cyc, mon_ev, grant_src);
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.cyc != cyc || mon_e.ev != mon_ev || mon_e.g != grant_src) begin
               errors++;
               $display("FAIL event cyc=%0d got ev=%b grant=%b want cyc=%0d ev=%b grant=%b",
                        cyc, mon_ev, grant_src, mon_e.cyc, mon_e.ev, mon_e.g);
            end
         end
      end
      if (chk_end && !end_done) begin
         end_done = 1'b1;
         checks++;
         if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_events got pending=%0d want 0 (next cyc=%0d ev=%b)",
                     sb.size(), sb[0].cyc, sb[0].ev);
         end
      end
   end

   initial begin
      int c0, d;

      // Navigation issue: src0 right on its own turn.
      current_player = 1'b0; win_flag = 2'b00;
      do_reset();
      c0 = cyc;
      exp_ev(c0,     1, 0, K_NONE,  0, 0, 0);
      exp_ev(c0 + 1, 0, 0, K_RIGHT, 0, 0, 0);
      src0_valid = 1'b1; src0_key = 3'd3;
      tick();
      src0_valid = 1'b0;
      repeat (3) tick();

      // Contention: owner src1 first, then src0 out of turn is dropped.
      current_player = 1'b1;
      do_reset();
      c0 = cyc;
      exp_ev(c0,     0, 1, K_NONE, 0, 0, 0);
      exp_ev(c0 + 1, 1, 0, K_UP,   0, 0, 1);
      exp_ev(c0 + 2, 0, 0, K_NONE, 1, 0, 1);
      src0_valid = 1'b1; src0_key = 3'd0;
      src1_valid = 1'b1; src1_key = 3'd0;
      tick();
      src1_valid = 1'b0;
      tick();
      src0_valid = 1'b0;
      repeat (3) tick();

      // Enter settle: full ENTER_WAIT window, then early exit on turn change.
      current_player = 1'b0;
      do_reset();
      c0 = cyc;
      exp_ev(c0,     1, 0, K_NONE,  0, 0, 0);
      exp_ev(c0 + 1, 0, 0, K_ENTER, 0, 0, 0);
      exp_ev(c0 + 5, 1, 0, K_NONE,  0, 0, 0);
      exp_ev(c0 + 6, 0, 0, K_UP,    0, 0, 0);
      src0_valid = 1'b1; src0_key = 3'd4;
      tick();
      src0_key = 3'd0;
      repeat (5) tick();
      src0_valid = 1'b0;
      tick();
      d = cyc;
      exp_ev(d,     1, 0, K_NONE,  0, 0, 0);
      exp_ev(d + 1, 0, 0, K_ENTER, 0, 0, 0);
      exp_ev(d + 4, 0, 1, K_NONE,  0, 0, 0);
      exp_ev(d + 5, 0, 0, K_UP,    0, 0, 1);
      src0_valid = 1'b1; src0_key = 3'd4;
      tick();
      src0_valid = 1'b0;
      src1_valid = 1'b1; src1_key = 3'd0;
      tick();
      tick();
      current_player = 1'b1;
      tick();
      tick();
      src1_valid = 1'b0;
      repeat (3) tick();

      // Game over: space passes with holdoff, enter is dropped.
      current_player = 1'b0; win_flag = 2'b01;
      do_reset();
      c0 = cyc;
      exp_ev(c0,     0, 1, K_NONE,  0, 0, 0);
      exp_ev(c0 + 1, 0, 0, K_SPACE, 0, 0, 1);
      exp_ev(c0 + 4, 1, 0, K_NONE,  0, 0, 1);
      exp_ev(c0 + 5, 0, 0, K_NONE,  1, 0, 1);
      src1_valid = 1'b1; src1_key = 3'd5;
      tick();
      src1_valid = 1'b0;
      src0_valid = 1'b1; src0_key = 3'd4;
      repeat (4) tick();
      src0_valid = 1'b0;
      repeat (3) tick();

      // Timeout with no keys: two periods.
      current_player = 1'b1; win_flag = 2'b00;
      do_reset();
      c0 = cyc;
`ifdef TTT_AUTO_MOVE_EN
      exp_ev(c0 + 19, 0, 0, K_ENTER, 0, 1, 1);
      exp_ev(c0 + 43, 0, 0, K_ENTER, 0, 1, 1);
`else
      exp_ev(c0 + 19, 0, 0, K_NONE, 0, 1, 0);
      exp_ev(c0 + 39, 0, 0, K_NONE, 0, 1, 0);
`endif
      repeat (45) tick();

      // Accept on the 20th idle cycle beats the timeout.
      do_reset();
      c0 = cyc;
      exp_ev(c0 + 19, 0, 1, K_NONE, 0, 0, 0);
      exp_ev(c0 + 20, 0, 0, K_LEFT, 0, 0, 1);
      repeat (19) tick();
      src1_valid = 1'b1; src1_key = 3'd2;
      tick();
      src1_valid = 1'b0;
      repeat (5) tick();

      // Reset while in WAIT_TURN.
      current_player = 1'b1;
      do_reset();
      c0 = cyc;
      exp_ev(c0,     0, 1, K_NONE,  0, 0, 0);
      exp_ev(c0 + 1, 0, 0, K_ENTER, 0, 0, 1);
      exp_ev(c0 + 4, 0, 1, K_NONE,  0, 0, 0);
      exp_ev(c0 + 5, 0, 0, K_DOWN,  0, 0, 1);
      src1_valid = 1'b1; src1_key = 3'd4;
      tick();
      src1_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_zero = 1'b1;
      tick();
      chk_zero = 1'b0;
      src1_valid = 1'b1; src1_key = 3'd1;
      tick();
      src1_valid = 1'b0;
      repeat (3) tick();

      chk_end = 1'b1;
      tick();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ttt_move_arbiter.md
Name: ttt_move_arbiter

Overview:
Shares the game controller's key-pulse inputs (up/down/left/right/enter/space) between two move sources: source 0 is the UART player, source 1 is the on-board buttons or a second player.
- Enforces turn ownership from current_player.
- Serialises one key pulse at a time.
- Sequences the settle windows after enter and space.
- Runs a per-turn inactivity timeout.

It sits between the key sources and ttt_ctrl in the 25 MHz domain.

Parameters:
TIMEOUT_CYCLES, 250000000, idle cycles allowed per turn before timeout (10 s at 25 MHz); must be >= 2.
ENTER_WAIT, 16, maximum cycles to wait for a turn change after an enter pulse.
HOLDOFF, 4, cycles blocked after a space pulse so ttt_ctrl can clear the board.

Ports:
clk  in  1  game clock (clk25)
reset  in  1  synchronous, active-high reset
src0_valid  in  1  source 0 has a key
src0_key  in  3  source 0 key code: 0 up, 1 down, 2 left, 3 right, 4 enter, 5 space, 6-7 invalid
src0_ready  out  1  source 0 key accepted this cycle
src1_valid  in  1  source 1 has a key
src1_key  in  3  source 1 key code, same encoding
src1_ready  out  1  source 1 key accepted this cycle
current_player  in  1  turn owner from ttt_ctrl (0 = source 0)
win_flag  in  2  nonzero = game over
up, down, left, right, enter, space  out  1 each  single-cycle key pulses to ttt_ctrl
grant_src  out  1  source of the most recently issued pulse
drop  out  1  one-cycle pulse: an accepted key was discarded
turn_timeout  out  1  one-cycle pulse on inactivity timeout

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset mid-operation abandons the current state and issues no pulse on the following cycle.
- Handshake: a transfer happens when valid && ready. Ready may be high only in IDLE, and at most one ready is high per cycle.
- Arbitration in IDLE:
  - Only one source valid: that source is granted.
  - Both valid: the turn owner (index == current_player) wins; the other source's ready stays low and it must hold its key.
- Eligibility of the accepted key:
  - Codes 0-4 are eligible only if the source index == current_player and win_flag == 0.
  - Code 5 (space) is always eligible.
  - Ineligible or invalid (6-7) keys are still accepted. They produce a drop pulse on the next cycle and no key pulse, and the state stays IDLE.
- Latency: an eligible accept at cycle N drives exactly one matching key pulse at cycle N+1. grant_src updates at N+1 and holds until the next issue.
- States:
  - IDLE: as above.
  - After an enter issue, go to WAIT_TURN. Return to IDLE when current_player toggles, win_flag becomes nonzero, or ENTER_WAIT cycles elapse, whichever comes first. The last case covers an occupied cell.
  - After a space issue, go to HOLDOFF for exactly HOLDOFF cycles, then IDLE.
  - After a navigation issue (codes 0-3), stay in IDLE, so back-to-back accepts are possible every cycle.
- Timeout counter, width $clog2(TIMEOUT_CYCLES):
  - Increments each IDLE cycle while win_flag == 0.
  - Clears to 0 on any eligible accept, on current_player toggle, and while win_flag != 0 or the state is not IDLE.
  - When the count reaches TIMEOUT_CYCLES-1: pulse turn_timeout for one cycle and clear the counter.
  - If the timeout and an accept fall in the same cycle, the accept wins: counter cleared, no timeout pulse.
- Game over (win_flag != 0): only space is issued; all other keys are dropped.

Optional Feature:
TTT_AUTO_MOVE_EN
- Defined: on turn_timeout, the arbiter also drives an enter pulse in the same cycle, with grant_src = current_player, then enters WAIT_TURN. This places a mark at the current cursor. No source ready is asserted that cycle.
- Undefined: turn_timeout is a flag only and the state is unchanged.

Test Plan (bench parameters: TIMEOUT_CYCLES=20, ENTER_WAIT=4, HOLDOFF=3):
- Navigation issue: current_player=0, src0 sends key 3 at cycle 10 -> src0_ready=1 at cycle 10, right=1 only at cycle 11, grant_src=0.
- Contention: both sources valid with key 0, current_player=1 -> src1 accepted first and up pulses next cycle; src0 accepted the following cycle and produces a drop pulse (not its turn), no up pulse.
- Enter settle: src0 enter with current_player=0, and current_player held at 0 -> enter pulse, no ready for 4 cycles, then IDLE. Repeat, toggling current_player 2 cycles after the pulse -> IDLE immediately after the toggle.
- Space in game over: win_flag=2'b01, src1 sends space, then src0 sends key 4 -> space pulse and 3 blocked cycles; then enter dropped with drop=1.
- Timeout: no keys for 20 IDLE cycles with win_flag=0 -> turn_timeout pulses on cycle 20 of idling and again 20 cycles later. An accept on the 20th cycle -> no pulse. With TTT_AUTO_MOVE_EN defined -> enter pulses in the same cycle.
- Reset in WAIT_TURN: reset asserted one cycle -> all outputs 0, ready available the cycle after reset deasserts.
